// File: rtl/kb_ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame geometry and
// microsecond-to-cycle conversion.
package kb_ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle
  } kb_state_e;

  // Device clock falling edges per host-to-device frame: 8 data, parity, stop, ACK.
  localparam int unsigned FrameLen = 11;
  localparam int unsigned DataBits = 8;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return clk_hz / 1000000 * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line plus falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Reset to 1 so an idle (released) bus never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/kb_host_tx.sv
// PS/2 host-to-keyboard command transmitter: request-to-send, clocked-out frame driven
// by the device clock, ACK check and timeout recovery.
module kb_host_tx
  import kb_ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       clk_kb_i,
  output logic       clk_kb_oe,
  input  logic       data_kb_i,
  output logic       data_kb_oe
);

  localparam int unsigned InhibitCycles = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TimeoutCycles = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned MaxCycles     = (InhibitCycles > TimeoutCycles) ? InhibitCycles
                                                                          : TimeoutCycles;
  localparam int unsigned CntW          = $clog2(MaxCycles + 1);
  localparam int unsigned ShW           = DataBits + 2;

  localparam logic [CntW-1:0] InhibitLast = CntW'(InhibitCycles - 1);
  localparam logic [CntW-1:0] InhibitPre  = CntW'(InhibitCycles - 2);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  // The REQ edge drives d0; SEND then drives d1..d7, parity and stop.
  localparam logic [3:0]      LastSend    = 4'(FrameLen - 3);

  kb_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [ShW-1:0]  shreg_q;
  logic [3:0]      bit_cnt_q;
  logic            ack_err_q;
  logic            clk_level, clk_fall;
  logic            data_level, unused_data_fall;
  logic            timeout;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (clk_kb_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (data_kb_i),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  assign timeout = (cnt_q == TimeoutLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ack_err_q  <= 1'b0;
      clk_kb_oe  <= 1'b0;
      data_kb_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      cnt_q <= cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (tx_start) begin
            shreg_q   <= {1'b1, ~^tx_data, tx_data};
            busy      <= 1'b1;
            clk_kb_oe <= 1'b1;
            state_q   <= StInhibit;
          end
        end
        StInhibit: begin
          // Start bit goes low while the clock is still held, one cycle before release.
          if (cnt_q == InhibitPre) data_kb_oe <= 1'b1;
          if (cnt_q == InhibitLast) begin
            clk_kb_oe <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StReq;
          end
        end
        default: begin
          if (timeout) begin
            clk_kb_oe  <= 1'b0;
            data_kb_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StIdle;
          end else begin
            if (clk_fall) cnt_q <= '0;
            unique case (state_q)
              StReq: begin
                if (clk_fall) begin
                  data_kb_oe <= ~shreg_q[0];
                  shreg_q    <= shreg_q >> 1;
                  bit_cnt_q  <= '0;
                  state_q    <= StSend;
                end
              end
              StSend: begin
                if (clk_fall) begin
                  data_kb_oe <= ~shreg_q[0];
                  shreg_q    <= shreg_q >> 1;
                  bit_cnt_q  <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LastSend) state_q <= StAck;
                end
              end
              StAck: begin
                if (clk_fall) begin
                  data_kb_oe <= 1'b0;
                  ack_err_q  <= data_level;
                  state_q    <= StWaitIdle;
                end
              end
              StWaitIdle: begin
                if (clk_level && data_level) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  err     <= ack_err_q;
                  cnt_q   <= '0;
                  state_q <= StIdle;
                end
              end
              default: state_q <= StIdle;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/kb_host_tx.md
KB_HOST_TX -- requirements
Module: kb_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 120, duration in microseconds that clk_kb is held low for request-to-send.
REQ-003 Parameter TIMEOUT_US, default 2000, maximum wait for any device clock edge or ACK.
REQ-004 Port clk, input, 1, system clock; all logic on its rising edge; one clock only.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port tx_data, input, 8, command byte to send to the keyboard (e.g. 0xED set-LEDs).
REQ-007 Port tx_start, input, 1, one-cycle request; accepted only when busy=0.
REQ-008 Port busy, output, 1, high from the cycle after acceptance until return to IDLE.
REQ-009 Port done, output, 1, one-cycle pulse on transfer end (success or error).
REQ-010 Port err, output, 1, valid with done; 1 = ACK missing or timeout.
REQ-011 Port clk_kb_i, input, 1, PS/2 clock line level (asynchronous).
REQ-012 Port clk_kb_oe, output, 1, 1 = pull PS/2 clock low; 0 = release (open drain).
REQ-013 Port data_kb_i, input, 1, PS/2 data line level (asynchronous).
REQ-014 Port data_kb_oe, output, 1, 1 = pull PS/2 data low; 0 = release.

Function
REQ-015 clk_kb_i and data_kb_i SHALL pass a 2-flop synchronizer; a falling edge of clk_kb SHALL be detected as synchronized previous=1, current=0.
REQ-016 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe=0; on tx_start, latch tx_data, compute odd parity (~^tx_data), go INHIBIT.
REQ-018 INHIBIT: clk_kb_oe=1 for INHIBIT_CYCLES = CLK_HZ/1000000*INHIBIT_US clocks; data_kb_oe=1 asserted in the last cycle of INHIBIT (start bit 0); then go REQ.
REQ-019 REQ: clk_kb_oe=0, data_kb_oe=1; on first clk_kb falling edge go SEND with bit index 0.
REQ-020 SEND: on each clk_kb falling edge drive next bit (data_kb_oe = ~bit): d0..d7 LSB first, then parity, then stop (oe=0); after the stop-bit edge go ACK.
REQ-021 ACK: on next clk_kb falling edge sample data_kb; 0 = ACK ok, 1 = err; go WAIT_IDLE.
REQ-022 WAIT_IDLE: wait until synchronized clk_kb=1 and data_kb=1, then pulse done, return IDLE.
REQ-023 Timeout counter SHALL reset on every clk_kb falling edge and on state entry; reaching TIMEOUT_CYCLES in REQ, SEND, ACK or WAIT_IDLE SHALL release both lines, pulse done with err=1, go IDLE.
REQ-024 tx_start while busy=1 SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-025 Frame SHALL be exactly 11 device falling edges after REQ: 8 data, parity, stop, ACK.
REQ-026 Falling edges in IDLE or INHIBIT (keyboard receive traffic) SHALL be ignored.

Reset
REQ-027 rst SHALL force state=IDLE, clk_kb_oe=0, data_kb_oe=0, busy=0, done=0, err=0, counters and shift register=0, synchronizers=1 (idle bus), asynchronously.
REQ-028 Reset mid-frame SHALL release both lines within zero clocks; no done pulse for the aborted frame.

Structure
REQ-029 Package kb_ps2_pkg SHALL hold state encoding, frame length (11), and the cycle-count computation for INHIBIT and TIMEOUT.
REQ-030 Sub-module ps2_line_sync (2-flop synchronizer plus falling-edge detect) SHALL be instantiated for clk_kb and reused for data_kb.

Verification
REQ-031 tx_data=0xED, device model clocks 11 edges and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, err=0.
REQ-032 tx_data=0x00 -> parity bit 1; tx_data=0x01 -> parity bit 0; both done=1, err=0.
REQ-033 Device leaves data high at ACK edge -> done=1, err=1; lines released.
REQ-034 Device never clocks after REQ -> after TIMEOUT_CYCLES, done=1, err=1, clk_kb_oe=0, data_kb_oe=0.
REQ-035 rst asserted after 4th data bit -> both oe=0 immediately, busy=0, no done; next tx_start 0xF4 completes, err=0.
REQ-036 Second tx_start pulse during frame -> ignored; only first byte appears on the line.
